// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles every bus signal between the write-back arbiter and its
// neighbours: the pipeline write-back, the cache-miss scoreboard
// updates, the refill valid/ready channel, the decode-stage operand
// lookup and the registered register-file write port.
//
// Signals
//   pipe_wr_en / pipe_waddr / pipe_wdata   pipeline write-back (no backpressure)
//   miss_issue / miss_rd                   load miss issued, marks miss_rd busy
//   fill_valid / fill_ready / fill_rd / fill_data   refill channel (valid/ready)
//   rs1 / rs2 / hazard_stall               decode operand lookup and stall
//   busy_mask                              registered scoreboard
//   reg_wr / waddr / wdata                 register-file write port (registered)
//
// Modports
//   master : the side producing results (pipeline, cache, decode)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32
);

  logic            pipe_wr_en;
  logic [4:0]      pipe_waddr;
  logic [XLEN-1:0] pipe_wdata;

  logic            miss_issue;
  logic [4:0]      miss_rd;

  logic            fill_valid;
  logic            fill_ready;
  logic [4:0]      fill_rd;
  logic [XLEN-1:0] fill_data;

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            hazard_stall;
  logic [31:0]     busy_mask;

  logic            reg_wr;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wdata;

  modport master (
    output pipe_wr_en, pipe_waddr, pipe_wdata,
    output miss_issue, miss_rd,
    output fill_valid, fill_rd, fill_data,
    output rs1, rs2,
    input  fill_ready, hazard_stall, busy_mask,
    input  reg_wr, waddr, wdata
  );

  modport slave (
    input  pipe_wr_en, pipe_waddr, pipe_wdata,
    input  miss_issue, miss_rd,
    input  fill_valid, fill_rd, fill_data,
    input  rs1, rs2,
    output fill_ready, hazard_stall, busy_mask,
    output reg_wr, waddr, wdata
  );

endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Write-back arbiter in front of the 32x32 register file write port.
// Merges the in-order pipeline write-back (always wins) with late miss
// load data from the cache controller, which is buffered in a small
// circular FIFO and drained only in cycles without a pipeline write.
// Keeps a per-register busy scoreboard for outstanding miss loads and
// flags a decode stall while a source operand is still pending.
// The write port outputs are registered; the register file samples them
// on the following falling edge.
//
// Parameters
//   FIFO_DEPTH  refill buffer entries, power of two, >= 2
//   XLEN        data width
//
// Ports
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous, active-low reset
//   bus    regfile_wb_arbiter_if.slave (see interface header)
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = 32
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  // refill buffer
  logic [4:0]      fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  // scoreboard
  logic [31:0]     busy_q;
  logic [31:0]     busy_d;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;

  // register-file write port
  logic            reg_wr_q;
  logic            reg_wr_d;
  logic [4:0]      waddr_q;
  logic [4:0]      waddr_d;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] wdata_d;

  // Pointers carry one extra wrap bit: equal means empty, differing only
  // in the wrap bit means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A fill is only ever stored here; it reaches the register file at the
  // earliest one edge after acceptance, never in its accept cycle.
  assign push = bus.fill_valid && !full;
  assign pop  = !bus.pipe_wr_en && !empty;

  assign head_rd   = fifo_rd[rd_ptr[AW-1:0]];
  assign head_data = fifo_data[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr[AW-1:0]]   <= bus.fill_rd;
      fifo_data[wr_ptr[AW-1:0]] <= bus.fill_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Set is applied after clear so a new miss to the register whose fill
  // is draining on the same edge keeps it busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (pop) begin
      clr_mask[head_rd] = 1'b1;
    end
    if (bus.miss_issue) begin
      set_mask[bus.miss_rd] = 1'b1;
    end
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Pipeline has fixed priority; the FIFO head goes out only when the
  // pipeline is idle. Address/data hold when nothing is written, and
  // x0 writes are suppressed through the enable only.
  always_comb begin
    reg_wr_d = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (bus.pipe_wr_en) begin
      reg_wr_d = (bus.pipe_waddr != 5'd0);
      waddr_d  = bus.pipe_waddr;
      wdata_d  = bus.pipe_wdata;
    end else if (!empty) begin
      reg_wr_d = (head_rd != 5'd0);
      waddr_d  = head_rd;
      wdata_d  = head_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_wr_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      reg_wr_q <= reg_wr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.fill_ready = !full;
  assign bus.busy_mask  = busy_q;
  assign bus.reg_wr     = reg_wr_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;

  // Looks only at the registered scoreboard, so there is no path from
  // the fill inputs to the stall.
  assign bus.hazard_stall = ((bus.rs1 != 5'd0) && busy_q[bus.rs1]) ||
                            ((bus.rs2 != 5'd0) && busy_q[bus.rs2]);

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter sitting directly upstream of the 32x32 register file write port. It merges two result sources: the in-order pipeline write-back (fixed priority, no backpressure) and late load data returned by the cache controller after a miss (valid/ready, buffered in a small FIFO). It keeps a per-register busy scoreboard for outstanding miss loads and raises a decode-stage stall when a source operand is still pending. Outputs are registered and drive the register file's `reg_wr`/`waddr`/`wdata` pins; the register file samples them on the following falling edge.

## Interface
- `FIFO_DEPTH`, 2: refill buffer entries; power of two, ≥2
- `XLEN`, 32: data width
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `pipe_wr_en`  in  1  pipeline write-back valid this cycle
- `pipe_waddr`  in  5  pipeline destination register
- `pipe_wdata`  in  XLEN  pipeline result
- `miss_issue`  in  1  load miss issued this cycle; marks `miss_rd` busy
- `miss_rd`  in  5  destination of the missing load
- `fill_valid`  in  1  refill result offered
- `fill_ready`  out  1  refill accepted when `fill_valid & fill_ready`
- `fill_rd`  in  5  refill destination register
- `fill_data`  in  XLEN  refill load data
- `rs1`, `rs2`  in  5 each  decode-stage source registers
- `hazard_stall`  out  1  combinational: a nonzero `rs1`/`rs2` is busy
- `busy_mask`  out  32  registered scoreboard; bit 0 always 0
- `reg_wr`  out  1  register-file write enable (registered)
- `waddr`  out  5  register-file write address (registered)
- `wdata`  out  XLEN  register-file write data (registered)

## Operation
- FIFO: circular, `log2(FIFO_DEPTH)+1`-bit read/write pointers, wrap by MSB compare; full when pointers differ only in MSB; empty when equal.
- `fill_ready = !full`; no pass-through (a fill is never written in its accept cycle). Push and pop in the same edge are both legal; count stays unchanged.
- Arbitration per cycle, fixed priority:
  - `pipe_wr_en=1`: next `reg_wr = (pipe_waddr != 0)`, `waddr/wdata` = pipe values; FIFO not popped.
  - else FIFO non-empty: pop head; next `reg_wr = (head rd != 0)`, `waddr/wdata` = head; clear `busy_mask[head rd]`.
  - else: next `reg_wr = 0`; `waddr`/`wdata` hold last value.
- Writes to x0 from either source are suppressed; an x0 fill is still popped.
- Scoreboard: `miss_issue` with `miss_rd != 0` sets the bit at the edge; a pop clears its bit at the same edge. Set and clear of the same register on one edge: set wins (newer miss).
- `hazard_stall = (rs1!=0 & busy_mask[rs1]) | (rs2!=0 & busy_mask[rs2])`; no combinational path from fill inputs.
- Protocol violations (bench asserts, RTL does not check): `pipe_wr_en` to a busy register; `fill_valid` for a non-busy register; `fill_valid` dropped or payload changed before acceptance.
- Starvation: FIFO drains only in cycles without `pipe_wr_en`; backpressure via `fill_ready=0` when full.

## Timing
- Reset asserted (async, immediate): `reg_wr=0`, `waddr=0`, `wdata=0`, FIFO empty, `busy_mask=0`, `hazard_stall=0`, `fill_ready=1`. Reset mid-operation discards buffered fills and all busy bits.
- Pipeline write: `pipe_wr_en` in cycle N → `reg_wr=1` during cycle N+1 → register file updated at falling edge inside N+1.
- Fill: accepted at edge ending cycle N, pipeline idle → popped at edge ending N+1 → `reg_wr=1` during N+2; busy bit clear and `hazard_stall` drops from start of N+2, so a read in N+2 sees the new value after the falling edge.
- Each cycle of `pipe_wr_en` delays a pending pop by one cycle.
- Throughput: one register-file write per cycle max.

## Test plan
- Reset: drive `reset=0` mid-traffic with two fills buffered → all outputs at reset values immediately, `fill_ready=1`, `busy_mask=0`; after release first write waits for new traffic.
- Pipeline only: `pipe_wr_en=1`, `pipe_waddr=5`, `pipe_wdata=0xDEADBEEF` → next cycle `reg_wr=1`, `waddr=5`, `wdata=0xDEADBEEF`; `pipe_waddr=0` → `reg_wr=0`.
- Miss round trip: `miss_issue`, `miss_rd=7`; `rs1=7` → `hazard_stall=1`; fill rd=7 data `0x12345678` with pipeline idle → write two cycles after acceptance, `busy_mask[7]` clears, stall drops same cycle.
- Priority/backpressure: `FIFO_DEPTH=2`, three fills (rd 3,4,6) back-to-back while `pipe_wr_en=1` continuously → `fill_ready=0` after two, third held; pipeline writes every cycle; after `pipe_wr_en` drops, writes 3,4,6 in order on consecutive cycles.
- Same-edge set/clear: pop fill rd=9 while `miss_issue` with `miss_rd=9` → `busy_mask[9]=1` afterwards; fill to x0 → popped, no write, `busy_mask[0]=0`.
- Random: ≥10k cycles of legal traffic vs. reference model of register contents and busy mask; zero mismatches, no lost or reordered fills.
